// File: rtl/dm_pkg.sv
// dm_pkg: DMType encodings, responder FSM states and type legality helper.
package dm_pkg;
  localparam logic [2:0] DM_WORD   = 3'd0;
  localparam logic [2:0] DM_HALF   = 3'd1;
  localparam logic [2:0] DM_HALF_U = 3'd2;
  localparam logic [2:0] DM_BYTE   = 3'd3;
  localparam logic [2:0] DM_BYTE_U = 3'd4;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  function automatic logic is_legal_type(input logic [2:0] t);
    return t <= DM_BYTE_U;
  endfunction
endpackage

// File: rtl/dm_lane_unit.sv
// dm_lane_unit: byte-lane steering for loads and stores of word/half/byte accesses.
module dm_lane_unit
  import dm_pkg::*;
(
  input  logic [2:0]  dm_type,
  input  logic [1:0]  lane,
  input  logic [31:0] raw,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] merged,
  output logic [31:0] load,
  output logic        misalign
);
  logic is_word, is_half, is_byte;
  logic [31:0] wrep;
  logic [15:0] h;
  logic [7:0] b;
  always_comb begin
    is_word  = dm_type == DM_WORD;
    is_half  = dm_type == DM_HALF || dm_type == DM_HALF_U;
    is_byte  = dm_type == DM_BYTE || dm_type == DM_BYTE_U;
    be       = is_word ? 4'hf : is_half ? (lane[1] ? 4'hc : 4'h3) : is_byte ? 4'b0001 << lane : 4'h0;
    misalign = (is_word && lane != 2'd0) || (is_half && lane[0]);
    // Replicate store data across all lanes so the enables alone pick the target bytes.
    wrep     = is_word ? wdata : is_half ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
    b        = raw[{lane, 3'b000} +: 8];
    h        = lane[1] ? raw[31:16] : raw[15:0];
    load     = is_word ? raw :
               dm_type == DM_HALF   ? {{16{h[15]}}, h} :
               dm_type == DM_HALF_U ? {16'h0, h} :
               dm_type == DM_BYTE   ? {{24{b[7]}}, b} :
               dm_type == DM_BYTE_U ? {24'h0, b} : 32'h0;
  end
  genvar i;
  for (i = 0; i < 4; i++) begin : g_lane
    assign merged[8*i +: 8] = be[i] ? wrep[8*i +: 8] : raw[8*i +: 8];
  end
endmodule

// File: rtl/dm_responder.sv
// dm_responder: handshaked data-memory responder with programmable access latency.
module dm_responder
  import dm_pkg::*;
#(
  parameter int DEPTH_WORDS = 128,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  state_t state, state_n;
  logic [3:0] cnt;
  logic we_q, cur_we, exec, err, misalign;
  logic [2:0] type_q, cur_type;
  logic [31:0] addr_q, wdata_q, cur_addr, cur_wdata, raw, merged, load;
  logic [3:0] be;
  logic [31:0] mem [DEPTH_WORDS];
  // With LATENCY==1 the access executes on the accept edge, so use the live request.
  always_comb begin
    cur_we    = state == IDLE ? req_we : we_q;
    cur_type  = state == IDLE ? req_type : type_q;
    cur_addr  = state == IDLE ? req_addr : addr_q;
    cur_wdata = state == IDLE ? req_wdata : wdata_q;
    err       = !is_legal_type(cur_type) || misalign || cur_addr >= 32'(DEPTH_WORDS * 4);
    exec      = (state == IDLE && req_valid && LATENCY == 1) || (state == WAIT && cnt == 4'd1);
    state_n   = state;
    if (state == IDLE && req_valid) state_n = LATENCY == 1 ? RESP : WAIT;
    else if (state == WAIT && cnt == 4'd1) state_n = RESP;
    else if (state == RESP && resp_ready) state_n = IDLE;
  end
  assign raw        = mem[cur_addr[AW+1:2]];
  assign req_ready  = state == IDLE;
  assign resp_valid = state == RESP;
  dm_lane_unit u_lane (
    .dm_type (cur_type),
    .lane    (cur_addr[1:0]),
    .raw     (raw),
    .wdata   (cur_wdata),
    .be      (be),
    .merged  (merged),
    .load    (load),
    .misalign(misalign)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && req_valid) begin
        we_q    <= req_we;
        type_q  <= req_type;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        cnt     <= 4'(LATENCY - 1);
      end else if (state == WAIT) cnt <= cnt - 4'd1;
      if (exec) begin
        resp_rdata <= (err || cur_we) ? 32'h0 : load;
        resp_err   <= err;
      end
    end
  end
  always_ff @(posedge clk)
    if (!reset && exec && cur_we && !err && be != 4'h0) mem[cur_addr[AW+1:2]] <= merged;
endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: directed checks of dm_responder loads, stores, errors, backpressure and reset.
module tb_dm_responder;
  logic clk = 0, reset = 1, req_valid = 0, req_we = 0, resp_ready = 0;
  logic [2:0] req_type = 0;
  logic [31:0] req_addr = 0, req_wdata = 0, resp_rdata;
  logic req_ready, resp_valid, resp_err;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  dm_responder #(.DEPTH_WORDS(128), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  task automatic drive(input logic we, input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1; req_we = we; req_type = t; req_addr = a; req_wdata = d;
  endtask
  // One full transaction: accept, measure latency, check response, handshake.
  task automatic xact(input string tag, input logic we, input logic [2:0] t, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    @(negedge clk);
    check({tag, ".ready"}, {31'h0, req_ready}, 32'h1);
    drive(we, t, a, d);
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    n = 1;
    while (!resp_valid && n < 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check({tag, ".lat"}, n, 2);
    check({tag, ".rdata"}, resp_rdata, exp_rdata);
    check({tag, ".err"}, {31'h0, resp_err}, {31'h0, exp_err});
    resp_ready = 1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 0;
    check({tag, ".done"}, {30'h0, resp_valid, req_ready}, 32'h1);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.ready", {31'h0, req_ready}, 32'h1);
    check("rst.valid", {31'h0, resp_valid}, 32'h0);
    check("rst.rdata", resp_rdata, 32'h0);
    check("rst.err", {31'h0, resp_err}, 32'h0);
    reset = 0;
    xact("sw10", 1, 3'd0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    xact("lw10", 0, 3'd0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    xact("sw10b", 1, 3'd0, 32'h10, 32'h11223344, 32'h0, 0);
    xact("sb11", 1, 3'd3, 32'h11, 32'h00000080, 32'h0, 0);
    xact("lw10b", 0, 3'd0, 32'h10, 32'h0, 32'h11228044, 0);
    xact("lb11", 0, 3'd3, 32'h11, 32'h0, 32'hFFFFFF80, 0);
    xact("lbu11", 0, 3'd4, 32'h11, 32'h0, 32'h00000080, 0);
    xact("sh12", 1, 3'd1, 32'h12, 32'h1234ABCD, 32'h0, 0);
    xact("lh12", 0, 3'd1, 32'h12, 32'h0, 32'hFFFFABCD, 0);
    xact("lhu12", 0, 3'd2, 32'h12, 32'h0, 32'h0000ABCD, 0);
    xact("lw10c", 0, 3'd0, 32'h10, 32'h0, 32'hABCD8044, 0);
    xact("lbu13", 0, 3'd4, 32'h13, 32'h0, 32'h000000AB, 0);
    xact("sw20", 1, 3'd0, 32'h20, 32'h55667788, 32'h0, 0);
    xact("sw0", 1, 3'd0, 32'h0, 32'h0, 32'h0, 0);
    xact("sw40", 1, 3'd0, 32'h40, 32'h01020304, 32'h0, 0);
    xact("sw1fc", 1, 3'd0, 32'h1FC, 32'h0BADCAFE, 32'h0, 0);
    xact("lw1fc", 0, 3'd0, 32'h1FC, 32'h0, 32'h0BADCAFE, 0);
    xact("e.lw13", 0, 3'd0, 32'h13, 32'h0, 32'h0, 1);
    xact("e.sh21", 1, 3'd1, 32'h21, 32'hFFFF, 32'h0, 1);
    xact("e.lw20", 0, 3'd0, 32'h20, 32'h0, 32'h55667788, 0);
    xact("e.t6ld", 0, 3'd6, 32'h10, 32'h0, 32'h0, 1);
    xact("e.t6st", 1, 3'd6, 32'h10, 32'hFFFFFFFF, 32'h0, 1);
    xact("e.lw10", 0, 3'd0, 32'h10, 32'h0, 32'hABCD8044, 0);
    xact("e.lw200", 0, 3'd0, 32'h200, 32'h0, 32'h0, 1);
    xact("e.sw200", 1, 3'd0, 32'h200, 32'h12345678, 32'h0, 1);
    xact("e.lw0", 0, 3'd0, 32'h0, 32'h0, 32'h0, 0);
    // Backpressure: response held 5 cycles while a second request waits.
    @(negedge clk);
    drive(0, 3'd0, 32'h10, 32'h0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 3'd0, 32'h20, 32'h0);
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp.valid", {31'h0, resp_valid}, 32'h1);
      check("bp.rdata", resp_rdata, 32'hABCD8044);
      check("bp.err", {31'h0, resp_err}, 32'h0);
      check("bp.ready", {31'h0, req_ready}, 32'h0);
      @(posedge clk);
    end
    @(negedge clk);
    resp_ready = 1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 0;
    check("bp.idle", {30'h0, resp_valid, req_ready}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    check("bp.acc", {30'h0, resp_valid, req_ready}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("bp2.valid", {31'h0, resp_valid}, 32'h1);
    check("bp2.rdata", resp_rdata, 32'h55667788);
    resp_ready = 1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 0;
    // Reset during WAIT discards the pending store.
    drive(1, 3'd0, 32'h40, 32'hCAFEF00D);
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    reset = 1;
    @(posedge clk);
    @(negedge clk);
    check("rw.ready", {31'h0, req_ready}, 32'h1);
    check("rw.valid", {31'h0, resp_valid}, 32'h0);
    check("rw.rdata", resp_rdata, 32'h0);
    check("rw.err", {31'h0, resp_err}, 32'h0);
    // Reset and req_valid together: nothing accepted.
    drive(0, 3'd0, 32'h10, 32'h0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    reset = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rv.valid", {31'h0, resp_valid}, 32'h0);
    check("rv.ready", {31'h0, req_ready}, 32'h1);
    xact("rw.lw40", 0, 3'd0, 32'h40, 32'h0, 32'h01020304, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
